// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: format constants, field view and
// classification helpers used by the fp32 arithmetic units.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    function automatic logic is_nan(fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != 23'd0);
    endfunction

    function automatic logic is_inf(fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == 23'd0);
    endfunction

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(fp32_t x);
        return x.exp == 8'd0;
    endfunction

endpackage

// File: rtl/fadd_a1_lzc.sv
// 27-bit leading-zero counter for post-subtraction normalisation.
module fadd_a1_lzc (
    input  logic [26:0] din,
    output logic [4:0]  cnt,
    output logic        all_zero
);

    logic found;

    // Scan from the MSB; count stops at the first set bit (27 when empty).
    always_comb begin
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (din[i]) found = 1'b1;
                else        cnt   = cnt + 5'd1;
            end
        end
        all_zero = ~found;
    end

endmodule

// File: rtl/fadd_a1_core.sv
// Single-cycle binary32 adder with a registered result. Subnormal inputs
// and outputs are flushed to signed zero; rounding is nearest-even.
module fadd_a1_core
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] out
);

    fp32_t       op_a, op_b, op_x, op_y;
    logic [7:0]  exp_diff;
    logic [49:0] y_shift;
    logic [26:0] x_al, y_al;
    logic [27:0] sum;
    logic [26:0] diff, diff_norm;
    logic [4:0]  lzc_cnt;
    logic        diff_zero;
    logic        eff_sub;
    logic [26:0] m_norm;
    logic [9:0]  e_norm, e_rnd;
    logic        round_up;
    logic [24:0] mant_rnd;
    logic [22:0] frac_out;
    logic [31:0] res;
    logic [31:0] out_d, out_q;
    logic        out_valid_d, out_valid_q;

    assign op_a = a;
    assign op_b = b;

    fadd_a1_lzc u_lzc (
        .din      (diff),
        .cnt      (lzc_cnt),
        .all_zero (diff_zero)
    );

    // Swap to larger magnitude, align Y with guard/round/sticky, add or subtract.
    always_comb begin
        if ({op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac}) begin
            op_x = op_a;
            op_y = op_b;
        end else begin
            op_x = op_b;
            op_y = op_a;
        end
        eff_sub  = op_x.sign ^ op_y.sign;
        exp_diff = op_x.exp - op_y.exp;
        y_shift  = {1'b1, op_y.frac, 26'd0} >> exp_diff;
        if (exp_diff >= 8'd26) y_al = 27'd1;
        else                   y_al = {y_shift[49:24], |y_shift[23:0]};
        x_al      = {1'b1, op_x.frac, 3'b000};
        sum       = {1'b0, x_al} + {1'b0, y_al};
        diff      = x_al - y_al;
        diff_norm = diff << lzc_cnt;
    end

    // Normalise, then round to nearest-even on the guard/round/sticky bits.
    always_comb begin
        if (!eff_sub) begin
            if (sum[27]) begin
                m_norm = {sum[27:2], |sum[1:0]};
                e_norm = {2'b00, op_x.exp} + 10'd1;
            end else begin
                m_norm = sum[26:0];
                e_norm = {2'b00, op_x.exp};
            end
        end else begin
            m_norm = diff_norm;
            e_norm = {2'b00, op_x.exp} - {5'd0, lzc_cnt};
        end
        round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        mant_rnd = {1'b0, m_norm[26:3]} + {24'd0, round_up};
        e_rnd    = e_norm + {9'd0, mant_rnd[24]};
        frac_out = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    end

    // Special-case priority mux in front of the arithmetic result.
    always_comb begin
        if (is_nan(op_a) || is_nan(op_b))
            res = QNAN;
        else if (is_inf(op_a) && is_inf(op_b) && (op_a.sign != op_b.sign))
            res = QNAN;
        else if (is_inf(op_a))
            res = op_a;
        else if (is_inf(op_b))
            res = op_b;
        else if (is_zero(op_a) && is_zero(op_b))
            res = {op_a.sign & op_b.sign, 31'd0};
        else if (is_zero(op_b))
            res = op_a;
        else if (is_zero(op_a))
            res = op_b;
        else if (eff_sub && diff_zero)
            res = 32'd0;
        else if (e_norm[9] || (e_norm == 10'd0))
            res = {op_x.sign, 31'd0};
        else if (e_rnd >= 10'(EXP_MAX))
            res = op_x.sign ? NEG_INF : POS_INF;
        else
            res = {op_x.sign, e_rnd[7:0], frac_out};
    end

    // Output holds unless a new valid operand pair arrives.
    always_comb begin
        out_valid_d = in_valid;
        out_d       = in_valid ? res : out_q;
    end

    // Result register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fadd_a1_core.sv
// Self-checking bench for fadd_a1_core: a double-precision reference model
// (rounded to binary32 nearest-even, flush-to-zero) checked every cycle.
module tb_fadd_a1_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_out = 32'd0;
    logic        m_valid = 1'b0;

    fadd_a1_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) d = {x[31], 63'd0};
        else d = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Exact-enough double sum, then one rounding to binary32.
    function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y);
        logic        nan_x, nan_y, inf_x, inf_y, g, st;
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        real         s;
        nan_x = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        nan_y = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        inf_x = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        inf_y = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (nan_x || nan_y) return 32'h7FC00000;
        if (inf_x && inf_y && (x[31] != y[31])) return 32'h7FC00000;
        if (inf_x) return x;
        if (inf_y) return y;
        s = f2r(x) + f2r(y);
        d = $realtobits(s);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'd0};
        m  = {2'b01, d[51:29]};
        g  = d[28];
        st = |d[27:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    // Reference register: mirrors the observable out/out_valid behaviour.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   = 32'd0;
            m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) m_out = model_add(a, b);
        end
    end

    // Every-cycle comparison just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("cyc_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("cyc_out", out, m_out);
        end
    end

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic v);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = v;
    endtask

    task automatic directed(input string name, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] expv);
        check({name, "_model"}, model_add(va, vb), expv);
        drive(va, vb, 1'b1);
        @(posedge clk);
        #2;
        check(name, out, expv);
        check({name, "_v"}, {31'd0, out_valid}, 32'd1);
    endtask

    function automatic logic [31:0] rand_special();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h7F800000;
            3:       return 32'hFF800000;
            4:       return 32'h7FC00000;
            5:       return {r[31], 8'hFF, r[22:1], 1'b1};
            6:       return {r[31], 8'h00, r[22:0]};
            default: return {r[31], 31'h7F7FFFFF};
        endcase
    endfunction

    task automatic rand_pair(output logic [31:0] ra, output logic [31:0] rb);
        logic [31:0] r1, r2;
        logic [7:0]  eo;
        r1 = $urandom;
        r2 = $urandom;
        ra = r1;
        eo = 8'($urandom_range(0, 30));
        case ($urandom_range(0, 9))
            0, 1, 2: rb = r2;
            3:       rb = rand_special();
            4: begin ra = rand_special(); rb = r2; end
            5:       rb = {~r1[31], r1[30:23], r2[22:0]};
            6:       rb = {~r1[31], r1[30:0] ^ {23'd0, r2[8:0]}};
            7:       rb = {r2[31], r1[30:23] - eo, r2[22:0]};
            8:       rb = {~r1[31], r1[30:0]};
            default: rb = {r2[31], r1[30:23] + 8'(eo[1:0]), r2[22:0]};
        endcase
    endtask

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] r1 [4];
    logic [31:0] ra, rb;

    initial begin
        #1;
        check("rst_out", out, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        directed("tie_even_lo", 32'h4B800000, 32'h3F800000, 32'h4B800000);
        directed("tie_even_up", 32'h4B800001, 32'h3F800000, 32'h4B800002);
        directed("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
        directed("negzero", 32'h80000000, 32'h80000000, 32'h80000000);
        directed("mixzero", 32'h00000000, 32'h80000000, 32'h00000000);
        directed("subnorm", 32'h00000001, 32'h00000000, 32'h00000000);
        directed("inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        directed("snan", 32'h7FA00000, 32'h3F800000, 32'h7FC00000);
        directed("xplus0", 32'hC9D532B0, 32'h00000000, 32'hC9D532B0);
        directed("one_5x2", 32'h3FC00000, 32'h3FC00000, 32'h40400000);

        // Hold with in_valid low, then an asynchronous reset pulse between edges.
        drive(32'h12345678, 32'h3F800000, 1'b0);
        @(posedge clk);
        #2;
        check("hold_out", out, 32'h40400000);
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_out", out, 32'd0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Four back-to-back pairs, then the same pairs swapped.
        for (int i = 0; i < 4; i++) begin
            rand_pair(ra, rb);
            pa[i] = ra;
            pb[i] = rb;
        end
        pa[0] = 32'h3FC00000; pb[0] = 32'h40000000;
        for (int i = 0; i < 4; i++) begin
            drive(pa[i], pb[i], 1'b1);
            @(posedge clk);
            #2;
            r1[i] = out;
            check("stream", out, model_add(pa[i], pb[i]));
        end
        check("stream_first", r1[0], 32'h40600000);
        for (int i = 0; i < 4; i++) begin
            drive(pb[i], pa[i], 1'b1);
            @(posedge clk);
            #2;
            check("swap", out, r1[i]);
        end

        // Randomized traffic with sporadic idle cycles, swaps and one mid-stream reset.
        for (int i = 0; i < 4000; i++) begin
            rand_pair(ra, rb);
            if ($urandom_range(0, 1) == 0) drive(ra, rb, ($urandom_range(0, 4) != 0));
            else                           drive(rb, ra, ($urandom_range(0, 4) != 0));
            if (i == 2000) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_out", out, 32'd0);
                rst_n = 1'b1;
            end
        end
        drive(32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
